// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared state, mode and channel encodings for the demux scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic MODE_DIR = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // Channel advance with natural 2-bit wrap (d -> a).
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_4xnbit.sv
// ============================================================================
// Module : demux_4xnbit
// Brief  : 4-way n-bit demultiplexer; unselected or disabled outputs are zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_4xnbit
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [1:0]   sel,
  input  logic         en,
  input  logic [n-1:0] din,
  output logic [n-1:0] out_a,
  output logic [n-1:0] out_b,
  output logic [n-1:0] out_c,
  output logic [n-1:0] out_d
);

  always_comb begin
    out_a = '0;
    out_b = '0;
    out_c = '0;
    out_d = '0;
    if (en) begin
      case (sel)
        CH_A:    out_a = din;
        CH_B:    out_b = din;
        CH_C:    out_c = din;
        default: out_d = din;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sched_timeout_cnt.sv
// ============================================================================
// Module : sched_timeout_cnt
// Brief  : Stall timer; pulses expire in the TIMEOUT-th consecutive stall cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sched_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic expire
);

  localparam int CNTW = $clog2(TIMEOUT) + 1;

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam logic [CNTW-1:0] c_last = CNTW'(TIMEOUT - 1);
      localparam logic [CNTW-1:0] c_one  = CNTW'(1);

      logic [CNTW-1:0] r_cnt;

      assign expire = stall && (r_cnt == c_last);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (clr || expire) begin
          r_cnt <= '0;
        end else if (stall) begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end else begin : g_no_timer
      // A zero limit means the scheduler waits on a stalled sink forever.
      assign expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/demux_4xnbit_sched.sv
// ============================================================================
// Module : demux_4xnbit_sched
// Brief  : Single-word valid/ready sequencer driving a 4-way demux bus with
//          directed or round-robin channel selection and stall skipping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_4xnbit_sched
  import demux_pkg::*;
#(
  parameter int n       = 8,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_data,
  input  logic [1:0]    in_dest,
  output logic [1:0]    sel,
  output logic [n-1:0]  out_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic          busy,
  output logic [CW-1:0] skip_cnt
);

  localparam logic [CW-1:0] c_skip_one = CW'(1);

  state_t        r_state;
  logic [n-1:0]  r_data;
  logic [1:0]    r_sel;
  logic [1:0]    r_rr_ptr;
  logic          r_mode;
  logic [CW-1:0] r_skip;

  logic w_hold;
  logic w_sink_rdy;
  logic w_stall;
  logic w_expire;

  assign w_hold     = (r_state == ST_HOLD);
  assign w_sink_rdy = out_ready[r_sel];
  // Only round-robin words may time out; directed words wait indefinitely.
  assign w_stall    = w_hold && (r_mode == MODE_RR) && !w_sink_rdy;

  sched_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_hold),
    .stall  (w_stall),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_sel    <= CH_A;
      r_rr_ptr <= CH_A;
      r_mode   <= MODE_DIR;
      r_skip   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_sel   <= (mode == MODE_DIR) ? in_dest : r_rr_ptr;
            r_mode  <= mode;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_sink_rdy) begin
            r_state <= ST_IDLE;
            if (r_mode == MODE_RR) begin
              r_rr_ptr <= next_ch(r_sel);
            end
          end else if (w_expire) begin
            r_sel <= next_ch(r_sel);
            if (r_skip != '1) begin
              r_skip <= r_skip + c_skip_one;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-hot valid: a 1-bit demux of "held" steered by the select.
  demux_4xnbit #(
    .n (1)
  ) u_valid_dec (
    .sel   (r_sel),
    .en    (w_hold),
    .din   (1'b1),
    .out_a (out_valid[0]),
    .out_b (out_valid[1]),
    .out_c (out_valid[2]),
    .out_d (out_valid[3])
  );

  assign in_ready = !w_hold;
  assign busy     = w_hold;
  assign sel      = r_sel;
  assign out_data = r_data;
  assign skip_cnt = r_skip;

endmodule

`default_nettype wire

// File: tb/tb_demux_4xnbit_sched.sv
// ============================================================================
// Module : tb_demux_4xnbit_sched
// Brief  : Self-checking bench for demux_4xnbit_sched with a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demux_4xnbit_sched;

  localparam int N  = 8;
  localparam int T  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [1:0]    in_dest;
  logic [1:0]    sel;
  logic [N-1:0]  out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic          busy;
  logic [CW-1:0] skip_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  int m_skip   = 0;

  always #5 clk = ~clk;

  demux_4xnbit_sched #(
    .n       (N),
    .TIMEOUT (T),
    .CW      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .skip_cnt  (skip_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single edge; returns in the first HOLD cycle.
  task automatic send(input logic m, input logic [1:0] dst, input logic [N-1:0] d);
    mode     = m;
    in_dest  = dst;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (skip_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_skip: got %0d want 0", skip_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    out_ready = 4'b0100;
    send(1'b0, 2'd2, 8'hA5);
    n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL dir_out_valid: got %b want 0100", out_valid); end
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL dir_sel: got %0d want 2", sel); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL dir_out_data: got %h want a5", out_data); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL dir_hold: in_ready %b busy %b want 0 1", in_ready, busy); end
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin n_fail++; $display("FAIL dir_done: in_ready %b out_valid %b want 1 0000", in_ready, out_valid); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    out_ready = 4'b1111;
    mode      = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = vals[i];
      tick();
      n_checks++; if (sel !== 2'(i % 4) || out_valid !== (4'b0001 << (i % 4))) begin
        n_fail++; $display("FAIL rr_word%0d: sel %0d valid %b want sel %0d", i, sel, out_valid, i % 4);
      end
      n_checks++; if (out_data !== vals[i]) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", i, out_data, vals[i]); end
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_rate%0d: in_ready %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    m_rr = 1;
  endtask

  task automatic test_timeout;
    out_ready = 4'b1101;
    send(1'b1, 2'd0, 8'h5A);
    n_checks++; if (sel !== 2'd1 || out_valid !== 4'b0010) begin n_fail++; $display("FAIL to_start: sel %0d valid %b want 1 0010", sel, out_valid); end
    tick(); tick(); tick();
    n_checks++; if (sel !== 2'd1 || skip_cnt !== 8'd0) begin n_fail++; $display("FAIL to_early: sel %0d skip %0d want 1 0", sel, skip_cnt); end
    tick();
    n_checks++; if (sel !== 2'd2 || out_valid !== 4'b0100 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_skip: sel %0d valid %b busy %b want 2 0100 1", sel, out_valid, busy);
    end
    n_checks++; if (skip_cnt !== 8'd1) begin n_fail++; $display("FAIL to_skip_cnt: got %0d want 1", skip_cnt); end
    tick();
    n_checks++; if (in_ready !== 1'b1 || sel !== 2'd2) begin n_fail++; $display("FAIL to_deliver: in_ready %b sel %0d want 1 2", in_ready, sel); end
    m_skip = 1;
    m_rr   = 3;
    out_ready = 4'b1111;
    send(1'b1, 2'd0, 8'h01);
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL to_rr_ptr: sel %0d want 3", sel); end
    tick();
    send(1'b1, 2'd0, 8'h02);
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL to_rr_wrap: sel %0d want 0", sel); end
    tick();
    m_rr = 1;
  endtask

  task automatic test_ready_at_timeout;
    out_ready = 4'b0000;
    send(1'b1, 2'd0, 8'h77);
    n_checks++; if (sel !== 2'(m_rr)) begin n_fail++; $display("FAIL rat_start: sel %0d want %0d", sel, m_rr); end
    tick(); tick(); tick();
    out_ready = 4'b0010;
    tick();
    n_checks++; if (in_ready !== 1'b1 || sel !== 2'd1) begin n_fail++; $display("FAIL rat_deliver: in_ready %b sel %0d want 1 1", in_ready, sel); end
    n_checks++; if (skip_cnt !== 8'(m_skip)) begin n_fail++; $display("FAIL rat_skip: got %0d want %0d", skip_cnt, m_skip); end
    out_ready = 4'b0000;
    m_rr = 2;
  endtask

  task automatic test_directed_stall;
    int bad;
    out_ready = 4'b0000;
    send(1'b0, 2'd1, 8'hC3);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) mode = ~mode;
      n_checks++; if (out_valid !== 4'b0010 || in_ready !== 1'b0 || skip_cnt !== 8'(m_skip)) begin
        n_fail++; bad++;
        if (bad < 4) $display("FAIL dstall_cyc%0d: valid %b in_ready %b skip %0d want 0010 0 %0d", i, out_valid, in_ready, skip_cnt, m_skip);
      end
      tick();
    end
    out_ready = 4'b0010;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dstall_release: in_ready %b want 1", in_ready); end
    out_ready = 4'b1111;
    send(1'b1, 2'd0, 8'h10);
    n_checks++; if (sel !== 2'(m_rr)) begin n_fail++; $display("FAIL dstall_rr_kept: sel %0d want %0d", sel, m_rr); end
    tick();
    m_rr = (m_rr + 1) % 4;
  endtask

  task automatic test_reset_in_hold;
    out_ready = 4'b0000;
    send(1'b0, 2'd3, 8'h3C);
    n_checks++; if (out_valid !== 4'b1000 || out_data !== 8'h3C) begin n_fail++; $display("FAIL rih_hold: valid %b data %h want 1000 3c", out_valid, out_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rih_flush: valid %b in_ready %b want 0000 1", out_valid, in_ready); end
    n_checks++; if (sel !== 2'd0 || skip_cnt !== 8'd0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL rih_regs: sel %0d skip %0d data %h want 0 0 00", sel, skip_cnt, out_data);
    end
    m_rr = 0;
    m_skip = 0;
    out_ready = 4'b1111;
    send(1'b1, 2'd3, 8'h99);
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rih_rr_cleared: sel %0d want 0", sel); end
    tick();
    m_rr = 1;
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic         m;
      logic [1:0]   dst;
      logic [N-1:0] d;
      logic [3:0]   r;
      int start, cur, w, edges, skips, seen;
      m   = 1'($urandom_range(0, 1));
      dst = 2'($urandom_range(0, 3));
      d   = N'($urandom);
      r   = 4'($urandom_range(1, 15));
      if (m == 1'b0) r[dst] = 1'b1;
      // Model: walk the hold cycle by cycle from the rules.
      start = (m == 1'b1) ? m_rr : int'(dst);
      cur = start; w = 0; edges = 0; skips = 0;
      while (1) begin
        edges++;
        if (r[cur]) break;
        if (m == 1'b1 && w == T - 1) begin
          cur = (cur + 1) % 4; w = 0; skips++;
        end else begin
          w++;
        end
      end
      out_ready = r;
      send(m, dst, d);
      n_checks++; if (sel !== 2'(start) || out_data !== d) begin
        n_fail++; $display("FAIL rand%0d_accept: sel %0d data %h want %0d %h", k, sel, out_data, start, d);
      end
      seen = 0;
      for (int e = 1; e <= 30; e++) begin
        tick();
        if (in_ready === 1'b1) begin seen = e; break; end
      end
      n_checks++; if (seen != edges || sel !== 2'(cur)) begin
        n_fail++; $display("FAIL rand%0d_deliver: edges %0d sel %0d want %0d %0d", k, seen, sel, edges, cur);
      end
      if (m == 1'b1) m_rr = (cur + 1) % 4;
      m_skip = m_skip + skips;
      n_checks++; if (skip_cnt !== 8'(m_skip)) begin n_fail++; $display("FAIL rand%0d_skip: got %0d want %0d", k, skip_cnt, m_skip); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_timeout();
    test_ready_at_timeout();
    test_directed_stall();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
